edge_frame_capture: RTL and testbench
=====================================

// Module: edge_frame_capture
// PURPOSE
// - Downstream of the filter chain. Consumes the 8-bit Canny edge stream (vsync/hsync/de/data).
// - On request, captures exactly one full frame as a 1-bit-per-pixel bitmap.
// - Writes the bitmap byte-wise into a BRAM write port, where the plotter path-planner reads it.
// - Arms on i_start, syncs to the next frame start, packs 8 pixels per byte, then reports done or error.
// PARAMETERS
// - H_RES    170  active pixels per line
// - V_RES    120  active lines per frame
// - EDGE_TH  128  pixel is edge (bit=1) when i_data >= EDGE_TH
// - ADDR_W   12   write address width; must hold V_RES*BPL-1, BPL = ceil(H_RES/8)
// PORTS
// - clk      in   1       pixel clock
// - rstn     in   1       synchronous active-low reset
// - i_start  in   1       1-cycle capture request
// - i_vsync  in   1       frame sync, active high; rising edge = frame start
// - i_hsync  in   1       line sync (unused internally; not required for correctness)
// - i_de     in   1       pixel valid
// - i_data   in   8       edge pixel (0/255 from Canny)
// - o_we     out  1       memory write strobe
// - o_waddr  out  ADDR_W  byte address = row*BPL + byte_idx
// - o_wdata  out  8       packed pixels; bit0 = leftmost pixel
// - o_busy   out  1       high in ARM and CAPTURE
// - o_done   out  1       1-cycle pulse on good frame completion
// - o_err    out  1       sticky error; cleared by next accepted i_start
// BEHAVIOUR
// - Reset (rstn=0 at posedge clk): all outputs 0, state IDLE, all counters 0.
//   Mid-capture reset aborts with no further writes.
// - vsync_rise = i_vsync & ~vsync_d (vsync_d registered). de_fall = ~i_de & de_d.
// - FSM:
//   - IDLE: i_start -> ARM, o_err<=0.
//   - ARM: vsync_rise -> CAPTURE, row=col=0. Pixels seen in ARM are ignored.
//   - CAPTURE: de-high pixels are packed; de_fall ends a row.
//     - Ending row V_RES-1 -> DONE.
//     - vsync_rise in CAPTURE -> o_err<=1, -> IDLE (truncated frame).
//   - DONE: o_done=1 for exactly one cycle -> IDLE.
// - i_start outside IDLE is ignored; in IDLE the same-cycle vsync is not treated as frame start.
// - Packing: bit[col%8] = (i_data >= EDGE_TH). Pixels with col >= H_RES are dropped (no write).
//   - After the 8th bit of a byte (col%8==7), the byte is written.
//   - At de_fall with a partial byte pending, it is flushed zero-padded in the upper bits.
// - Write latency: o_we=1 with o_waddr/o_wdata in the cycle after the completing pixel
//   (or the cycle after the de_fall cycle for a flush).
//   - Registered outputs; o_we is high for one cycle per byte, at most one write per cycle.
// - Short row (de_fall with col < H_RES):
//   - pending partial byte flushed; missing bytes not written; o_err<=1.
//   - row still advances; capture continues.
// - Long row: extra pixels dropped, o_err<=1, no extra writes.
// - Bytes per frame on a clean frame = V_RES*BPL; o_done asserts 1 cycle after the last write.
// - Arithmetic: col 0..H_RES (clamped), row 0..V_RES-1, addr = row*BPL + col/8.
//   No wrap; address never exceeds V_RES*BPL-1.
// TESTING (bench uses H_RES=20, V_RES=3, BPL=3)
// - Reset: hold rstn=0 4 cycles with stimulus toggling -> o_we/o_busy/o_done/o_err all 0.
// - Clean frame, all pixels 255:
//   - 9 writes, addrs 0..8, data FF,FF,0F per row.
//   - o_done pulses 1 cycle after addr 8; o_err=0.
// - Pattern, pixel = 255 iff col even:
//   - row data 55,55,05; a pixel value of 127 maps to 0 and 128 maps to 1 at EDGE_TH=128.
// - i_start mid-frame: no writes until the next vsync rise; second i_start during CAPTURE is ignored.
// - vsync rises after row 1:
//   - o_err=1, state IDLE, no o_done, 6 writes total.
//   - next i_start clears o_err.
// - Row 1 has 13 pixels: row-1 writes are FF,1F only; o_err=1; row 2 is written at addrs 6..8.

Source files
------------

// File: rtl/edge_frame_capture.sv
// Captures one frame of the Canny edge stream as a 1-bit-per-pixel bitmap and
// writes it byte-wise (bit0 = leftmost pixel) into a BRAM write port.
module edge_frame_capture #(
   parameter int H_RES   = 170,
   parameter int V_RES   = 120,
   parameter int EDGE_TH = 128,
   parameter int ADDR_W  = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_start,
   input  logic              i_vsync,
   input  logic              i_hsync,
   input  logic              i_de,
   input  logic [7:0]        i_data,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [7:0]        o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int BPL = (H_RES + 7) / 8;
   localparam int CW  = $clog2(H_RES + 1);
   localparam int RW  = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                vsync_q;
   logic                de_q, de_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [7:0]          byte_q, byte_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                vsync_rise, de_fall;
   logic [7:0]          px_byte;
   logic                unused_hsync;

   assign unused_hsync = i_hsync;

   function automatic logic is_edge(input logic [7:0] px);
      return px >= 8'(EDGE_TH);
   endfunction

   assign vsync_rise = i_vsync & ~vsync_q;
   assign de_fall    = ~i_de & de_q;

   always_comb begin
      state_d = state_q;
      de_d    = i_de & (state_q == S_CAPTURE);
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      byte_d  = byte_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      err_d   = err_q;
      px_byte = byte_q | (8'(is_edge(i_data)) << col_q[2:0]);

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_ARM;
               err_d   = 1'b0;
            end
         end
         S_ARM: begin
            if (vsync_rise) begin
               state_d = S_CAPTURE;
               col_d   = '0;
               row_d   = '0;
               base_d  = '0;
               byte_d  = '0;
            end
         end
         S_CAPTURE: begin
            if (vsync_rise) begin
               // Frame restarted before the last row ended: truncated capture.
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (i_de) begin
               if (col_q < CW'(H_RES)) begin
                  col_d = col_q + 1'b1;
                  if (col_q[2:0] == 3'd7) begin
                     we_d    = 1'b1;
                     waddr_d = base_q + ADDR_W'(col_q >> 3);
                     wdata_d = px_byte;
                     byte_d  = '0;
                  end else begin
                     byte_d = px_byte;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else if (de_fall) begin
               // col_q is clamped at H_RES, so col_q/8 still lands inside the row.
               if (col_q[2:0] != 3'd0) begin
                  we_d    = 1'b1;
                  waddr_d = base_q + ADDR_W'(col_q >> 3);
                  wdata_d = byte_q;
               end
               if (col_q < CW'(H_RES)) err_d = 1'b1;
               col_d  = '0;
               byte_d = '0;
               if (row_q == RW'(V_RES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  row_d  = row_q + 1'b1;
                  base_d = base_q + ADDR_W'(BPL);
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         vsync_q <= 1'b0;
         de_q    <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         byte_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vsync_q <= i_vsync;
         de_q    <= de_d;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
         byte_q  <= byte_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_we    = we_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;
   assign o_done  = done_q;
   assign o_err   = err_q;
   assign o_busy  = (state_q == S_ARM) || (state_q == S_CAPTURE);

endmodule

// File: tb/tb_edge_frame_capture.sv
// Directed bench for edge_frame_capture with a write scoreboard (H_RES=20, V_RES=3).
module tb_edge_frame_capture;

   localparam int H   = 20;
   localparam int V   = 3;
   localparam int BPL = 3;
   localparam int AW  = 12;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_start = 1'b0;
   logic          i_vsync = 1'b0;
   logic          i_hsync = 1'b0;
   logic          i_de = 1'b0;
   logic [7:0]    i_data = 8'd0;
   logic          o_we;
   logic [AW-1:0] o_waddr;
   logic [7:0]    o_wdata;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   int vectors = 0;
   int miscompares = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_we = -10;
   logic [19:0] exp_q[$];
   logic [19:0] mon_e;

   always #5 clk = ~clk;

   edge_frame_capture #(
      .H_RES(H), .V_RES(V), .EDGE_TH(128), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_vsync(i_vsync),
      .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data), .o_we(o_we),
      .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every write must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rstn) begin
         if (o_we) begin
            wr_cnt++;
            last_we = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_write: observed addr %0d data %0h expected no write", o_waddr, o_wdata);
            end
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("waddr", 32'(o_waddr), 32'(mon_e[19:8]));
               check("wdata", 32'(o_wdata), 32'(mon_e[7:0]));
            end
         end
         if (o_done) begin
            done_cnt++;
            check("done_latency", 32'(cyc - last_we), 32'd1);
         end
      end
   end

   function automatic logic [7:0] pix(input int c, input int mode);
      case (mode)
         0:       return 8'd255;
         1:       return (c % 2 == 0) ? 8'd255 : 8'd0;
         default: return (c % 2 == 0) ? 8'd128 : 8'd127;
      endcase
   endfunction

   task automatic push_row(input int row, input int n, input int mode);
      int lim;
      logic [7:0] b8;
      lim = (n < H) ? n : H;
      for (int b = 0; b < BPL; b++) begin
         if (b * 8 < lim) begin
            b8 = 8'd0;
            for (int k = 0; k < 8; k++)
               if (b * 8 + k < lim && pix(b * 8 + k, mode) >= 8'd128) b8[k] = 1'b1;
            exp_q.push_back({12'(row * BPL + b), b8});
         end
      end
   endtask

   task automatic do_row(input int row, input int n, input int mode, input bit expect_wr);
      if (expect_wr) push_row(row, n, mode);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         i_de = 1'b1; i_hsync = 1'b0; i_data = pix(c, mode);
      end
      @(posedge clk); #1;
      i_de = 1'b0; i_hsync = 1'b1; i_data = 8'd0;
      repeat (3) begin @(posedge clk); #1; end
      i_hsync = 1'b0;
   endtask

   task automatic frame_start();
      @(posedge clk); #1 i_vsync = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      i_vsync = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 50 && done_cnt == d0; i++) @(posedge clk);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0;
      // Reset with toggling stimulus
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         i_start = 1'($urandom); i_vsync = 1'($urandom);
         i_de = 1'($urandom); i_data = 8'($urandom);
         @(negedge clk);
         check("rst_we",   32'(o_we),   32'd0);
         check("rst_busy", 32'(o_busy), 32'd0);
         check("rst_done", 32'(o_done), 32'd0);
         check("rst_err",  32'(o_err),  32'd0);
      end
      @(posedge clk); #1;
      i_start = 1'b0; i_vsync = 1'b0; i_de = 1'b0; i_data = 8'd0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(o_busy), 32'd0);

      // Clean frame, all 255
      d0 = done_cnt; w0 = wr_cnt;
      pulse_start();
      @(negedge clk);
      check("arm_busy", 32'(o_busy), 32'd1);
      frame_start();
      for (int r = 0; r < V; r++) do_row(r, H, 0, 1'b1);
      wait_done(d0);
      check("clean_writes", 32'(wr_cnt - w0), 32'd9);
      check("clean_err", 32'(o_err), 32'd0);
      check("clean_busy", 32'(o_busy), 32'd0);

      // Even-column pattern, including 128/127 threshold row
      d0 = done_cnt;
      pulse_start();
      frame_start();
      do_row(0, H, 1, 1'b1);
      do_row(1, H, 2, 1'b1);
      do_row(2, H, 1, 1'b1);
      wait_done(d0);
      check("pattern_err", 32'(o_err), 32'd0);

      // Start mid-frame waits for the next vsync; second start in CAPTURE ignored
      d0 = done_cnt; w0 = wr_cnt;
      frame_start();
      do_row(0, H, 0, 1'b0);
      pulse_start();
      do_row(1, H, 0, 1'b0);
      do_row(2, H, 0, 1'b0);
      check("armed_no_writes", 32'(wr_cnt - w0), 32'd0);
      check("armed_busy", 32'(o_busy), 32'd1);
      frame_start();
      do_row(0, H, 1, 1'b1);
      pulse_start();
      @(negedge clk);
      check("restart_ignored_busy", 32'(o_busy), 32'd1);
      do_row(1, H, 0, 1'b1);
      do_row(2, H, 1, 1'b1);
      wait_done(d0);
      check("midframe_writes", 32'(wr_cnt - w0), 32'd9);

      // Truncated frame: vsync rises after row 1
      d0 = done_cnt; w0 = wr_cnt;
      pulse_start();
      frame_start();
      do_row(0, H, 0, 1'b1);
      do_row(1, H, 1, 1'b1);
      frame_start();
      @(negedge clk);
      check("trunc_err", 32'(o_err), 32'd1);
      check("trunc_busy", 32'(o_busy), 32'd0);
      check("trunc_no_done", 32'(done_cnt - d0), 32'd0);
      check("trunc_writes", 32'(wr_cnt - w0), 32'd6);
      pulse_start();
      @(negedge clk);
      check("start_clears_err", 32'(o_err), 32'd0);
      d0 = done_cnt;
      frame_start();
      for (int r = 0; r < V; r++) do_row(r, H, 0, 1'b1);
      wait_done(d0);

      // Short row 1 (13 pixels)
      d0 = done_cnt; w0 = wr_cnt;
      pulse_start();
      frame_start();
      do_row(0, H, 0, 1'b1);
      do_row(1, 13, 0, 1'b1);
      do_row(2, H, 1, 1'b1);
      wait_done(d0);
      check("short_err", 32'(o_err), 32'd1);
      check("short_writes", 32'(wr_cnt - w0), 32'd8);

      // Long row 1 (23 pixels)
      d0 = done_cnt; w0 = wr_cnt;
      pulse_start();
      @(negedge clk);
      check("long_err_cleared", 32'(o_err), 32'd0);
      frame_start();
      do_row(0, H, 1, 1'b1);
      do_row(1, 23, 0, 1'b1);
      do_row(2, H, 0, 1'b1);
      wait_done(d0);
      check("long_err", 32'(o_err), 32'd1);
      check("long_writes", 32'(wr_cnt - w0), 32'd9);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
